path_dram_scheduler: RTL and testbench

PATH_DRAM_SCHEDULER -- requirements
Module: path_dram_scheduler

---
 rtl/path_dram_scheduler.sv | 255 +++++++++++++++++++++++++
 tb/tb_path_dram_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_dram_scheduler.sv
// -----------------------------------------------------------------------------
// path_dram_scheduler
//
// Turns one ORAM path operation into a stream of DRAM burst commands. A path
// is the chain of buckets from the root (level 0) to the addressed leaf
// (level ORAML). Each bucket is BktBursts DRAM bursts. A read phase issues one
// read command per burst. The read commands are throttled by ReadCredit, which
// counts the free slots in the downstream path buffer. A write phase issues one
// write command per burst. The write commands are throttled by WrAhead, which
// counts the write-data beats that DRAM has accepted ahead of their commands.
//
// Ports
//   Clock             in   sole clock, rising edge
//   Reset             in   asynchronous active-low reset
//   Op[1:0]           in   00 none, 01 read path, 10 write path, 11 read+write
//   Leaf[ORAML-1:0]   in   target leaf
//   OpValid/OpReady   in/out  operation handshake (OpReady only in IDLE)
//   DRAMAddress       out  byte address of the current burst
//   DRAMCommand       out  CmdRead / CmdWrite
//   DRAMCommandValid  out  command valid
//   DRAMCommandReady  in   DRAM accepts the command when Valid&Ready
//   WrBeatAccepted    in   pulse per write-data beat accepted by DRAM
//   BufDrain          in   pulse per burst removed from the path buffer
//   Done              out  one-cycle pulse when the operation completes
//   OverflowErr       out  sticky: BufDrain arrived with the buffer empty
//
// All outputs are registered. Their next values are derived from the
// next-state values, so a registered Valid appears in the same cycle in which
// a combinational Valid would have appeared.
// -----------------------------------------------------------------------------
module path_dram_scheduler #(
    parameter int ORAML     = 3,
    parameter int BktBursts = 2,
    parameter int AddrShift = 3,
    parameter int DDRAWidth = 27,
    parameter int DDRCWidth = 3,
    parameter int BufBursts = 8,
    parameter logic [DDRCWidth-1:0] CmdRead  = 3'b001,
    parameter logic [DDRCWidth-1:0] CmdWrite = 3'b000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [1:0]            Op,
    input  logic [ORAML-1:0]      Leaf,
    input  logic                  OpValid,
    output logic                  OpReady,
    output logic [DDRAWidth-1:0]  DRAMAddress,
    output logic [DDRCWidth-1:0]  DRAMCommand,
    output logic                  DRAMCommandValid,
    input  logic                  DRAMCommandReady,
    input  logic                  WrBeatAccepted,
    input  logic                  BufDrain,
    output logic                  Done,
    output logic                  OverflowErr
);

    localparam int LVW = (ORAML + 1 > 1) ? $clog2(ORAML + 1) : 1;
    localparam int BW  = (BktBursts > 1) ? $clog2(BktBursts) : 1;
    localparam int CRW = $clog2(BufBursts + 1);
    localparam int WAW = 8;

    localparam logic [LVW-1:0] LAST_LVL = LVW'(ORAML);
    localparam logic [BW-1:0]  LAST_BST = BW'(BktBursts - 1);
    localparam logic [CRW-1:0] CRED_MAX = CRW'(BufBursts);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    // Byte address of burst bst of the bucket at level lvl on the path to leaf.
    // The tree is stored in heap order, so level l starts at node 2^l - 1.
    function automatic logic [DDRAWidth-1:0] path_addr(
        input logic [LVW-1:0]   lvl,
        input logic [BW-1:0]    bst,
        input logic [ORAML-1:0] leaf
    );
        logic [63:0] node;
        logic [63:0] bidx;
        logic [63:0] shamt;
        shamt = 64'(ORAML) - 64'(lvl);
        node  = ((64'd1 << lvl) - 64'd1) + (64'(leaf) >> shamt);
        bidx  = (node * 64'(BktBursts)) + 64'(bst);
        bidx  = bidx << AddrShift;
        return bidx[DDRAWidth-1:0];
    endfunction

    // State and datapath registers.
    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [ORAML-1:0]   leaf_q, leaf_d;
    logic [LVW-1:0]     lvl_q, lvl_d;
    logic [BW-1:0]      bst_q, bst_d;
    logic [CRW-1:0]     cred_q, cred_d;
    logic [WAW-1:0]     wra_q, wra_d;
    logic               ovf_q, ovf_d;

    // Registered outputs.
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [DDRAWidth-1:0] addr_q, addr_d;
    logic [DDRCWidth-1:0] cmd_q, cmd_d;

    logic op_acc_s;
    logic cmd_acc_s;
    logic rd_acc_s;
    logic wr_acc_s;

    assign op_acc_s  = OpValid & ready_q & (state_q == S_IDLE);
    assign cmd_acc_s = valid_q & DRAMCommandReady;
    assign rd_acc_s  = cmd_acc_s & (state_q == S_READ);
    assign wr_acc_s  = cmd_acc_s & (state_q == S_WRITE);

    // Sequencer: operation latch, level/burst walk and phase transitions.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        leaf_d  = leaf_q;
        lvl_d   = lvl_q;
        bst_d   = bst_q;
        case (state_q)
            S_IDLE: begin
                if (op_acc_s) begin
                    op_d   = Op;
                    leaf_d = Leaf;
                    lvl_d  = '0;
                    bst_d  = '0;
                    case (Op)
                        2'b01, 2'b11: state_d = S_READ;
                        2'b10:        state_d = S_WRITE;
                        default:      state_d = S_FINISH;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ, S_WRITE: begin
                if (cmd_acc_s) begin
                    if (bst_q == LAST_BST) begin
                        bst_d = '0;
                        if (lvl_q == LAST_LVL) begin
                            lvl_d = '0;
                            // Only a combined operation follows its read
                            // phase with a write phase.
                            if ((state_q == S_READ) && (op_q == 2'b11)) begin
                                state_d = S_WRITE;
                            end else begin
                                state_d = S_FINISH;
                            end
                        end else begin
                            lvl_d = lvl_q + LVW'(1);
                        end
                    end else begin
                        bst_d = bst_q + BW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Read credit: free path-buffer slots. A drain that arrives while the
    // buffer is already empty is an error. In that case the count is held.
    always_comb begin
        cred_d = cred_q;
        ovf_d  = ovf_q;
        if (rd_acc_s && !BufDrain) begin
            cred_d = cred_q - CRW'(1);
        end else if (BufDrain && !rd_acc_s) begin
            if (cred_q == CRED_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cred_d = cred_q + CRW'(1);
            end
        end else begin
            cred_d = cred_q;
        end
    end

    // Write-ahead count: data beats accepted but not yet matched by a write
    // command. The count is kept across operations and saturates at its maximum.
    always_comb begin
        wra_d = wra_q;
        if (WrBeatAccepted && !wr_acc_s) begin
            if (wra_q != {WAW{1'b1}}) begin
                wra_d = wra_q + WAW'(1);
            end else begin
                wra_d = wra_q;
            end
        end else if (wr_acc_s && !WrBeatAccepted) begin
            wra_d = wra_q - WAW'(1);
        end else begin
            wra_d = wra_q;
        end
    end

    // Output next values, derived from the next state so that they line up
    // with the registered state. While a command is stalled none of the inputs
    // to addr_d/cmd_d change, so the command is held stable.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        valid_d = ((state_d == S_READ)  && (cred_d != '0)) ||
                  ((state_d == S_WRITE) && (wra_d  != '0));
        done_d  = (state_d == S_FINISH);
        addr_d  = path_addr(lvl_d, bst_d, leaf_d);
        cmd_d   = (state_d == S_WRITE) ? CmdWrite : CmdRead;
    end

    // State, counter and output registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            leaf_q  <= '0;
            lvl_q   <= '0;
            bst_q   <= '0;
            cred_q  <= CRED_MAX;
            wra_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            cmd_q   <= CmdRead;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            leaf_q  <= leaf_d;
            lvl_q   <= lvl_d;
            bst_q   <= bst_d;
            cred_q  <= cred_d;
            wra_q   <= wra_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
        end
    end

    assign OpReady          = ready_q;
    assign DRAMCommandValid = valid_q;
    assign DRAMAddress      = addr_q;
    assign DRAMCommand      = cmd_q;
    assign Done             = done_q;
    assign OverflowErr      = ovf_q;

endmodule

// File: tb/tb_path_dram_scheduler.sv
// -----------------------------------------------------------------------------
// Self-checking bench for path_dram_scheduler with default parameters.
// A table of path operations is run first, with hand-computed addresses. The
// bench then runs hand-written sequences for the following cases:
//   - read-credit overflow
//   - a read phase that starves its credit
//   - drain and beat supply withheld, so the read and write phases stall
//   - asynchronous reset during a read phase
// The bench keeps its own models of ReadCredit and WrAhead. It uses them to
// check, on every cycle of a phase, that Valid is asserted exactly when the
// model allows it.
// -----------------------------------------------------------------------------
module tb_path_dram_scheduler;

    logic        Clock;
    logic        Reset;
    logic [1:0]  Op;
    logic [2:0]  Leaf;
    logic        OpValid;
    logic        OpReady;
    logic [26:0] DRAMAddress;
    logic [2:0]  DRAMCommand;
    logic        DRAMCommandValid;
    logic        DRAMCommandReady;
    logic        WrBeatAccepted;
    logic        BufDrain;
    logic        Done;
    logic        OverflowErr;

    path_dram_scheduler dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Op               (Op),
        .Leaf             (Leaf),
        .OpValid          (OpValid),
        .OpReady          (OpReady),
        .DRAMAddress      (DRAMAddress),
        .DRAMCommand      (DRAMCommand),
        .DRAMCommandValid (DRAMCommandValid),
        .DRAMCommandReady (DRAMCommandReady),
        .WrBeatAccepted   (WrBeatAccepted),
        .BufDrain         (BufDrain),
        .Done             (Done),
        .OverflowErr      (OverflowErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0] op;
        logic [2:0] leaf;
        int         n_rd;
        int         n_wr;
        int         rdy;
        int         addr [8];
    } vec_t;

    vec_t        tbl [6];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [26:0] got_addr [$];
    logic [2:0]  got_cmd  [$];
    int          done_cnt;
    int          credit_m;
    int          wr_m;
    int          p_leaf0 [8];
    int          p_leaf7 [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // The task is called at a negedge. It returns at the negedge that follows
    // the handshake.
    task automatic issue_op(input logic [1:0] op, input logic [2:0] leaf);
        int w;
        w = 0;
        while (!OpReady && w < 20) begin
            @(negedge Clock);
            w++;
        end
        chk("opready_idle", OpReady, 1);
        Op      = op;
        Leaf    = leaf;
        OpValid = 1'b1;
        @(negedge Clock);
        OpValid = 1'b0;
        chk("opready_busy", OpReady, 0);
    endtask

    task automatic pulse_drain();
        BufDrain = 1'b1;
        if (credit_m < 8) credit_m++;
        @(negedge Clock);
        BufDrain = 1'b0;
    endtask

    // The task drives one operation until Done and records the accepted commands.
    // The drain modes are: 0 none, 1 one drain after each read, 2 a drain only
    // after a 3-cycle stall. The beat modes are: 0 none, 1 one beat per cycle up
    // to n_wr beats, 2 a beat only after a 2-cycle write stall.
    task automatic run_loop(input int n_rd, input int n_wr, input int rdy_mode,
                            input int drain_mode, input int beat_mode, input int budget);
        int          cyc, total, ng, stall_rd, stall_wr, beats_given;
        bit          in_rd, in_wr, pend, fin, prev_stall, acc, drn, bt;
        logic [26:0] pa;
        logic [2:0]  pc;
        got_addr.delete();
        got_cmd.delete();
        done_cnt = 0; cyc = 0; total = n_rd + n_wr;
        stall_rd = 0; stall_wr = 0; beats_given = 0;
        pend = 1'b0; fin = 1'b0; prev_stall = 1'b0; pa = '0; pc = '0;
        while (!fin && cyc < budget) begin
            ng    = got_addr.size();
            in_rd = (ng < n_rd);
            in_wr = !in_rd && (ng < total);
            if (Done) done_cnt++;
            if (in_rd) chk("valid_gate_rd", DRAMCommandValid, credit_m > 0);
            if (in_wr) chk("valid_gate_wr", DRAMCommandValid, wr_m > 0);
            if (prev_stall) begin
                chk("stall_valid", DRAMCommandValid, 1);
                chk("stall_addr", DRAMAddress, pa);
                chk("stall_cmd", DRAMCommand, pc);
            end
            DRAMCommandReady = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            drn  = pend;
            pend = 1'b0;
            if (drain_mode == 2 && in_rd && !DRAMCommandValid) begin
                stall_rd++;
                if (stall_rd >= 3) begin drn = 1'b1; stall_rd = 0; end
            end
            bt = 1'b0;
            if (beat_mode == 1 && beats_given < n_wr) bt = 1'b1;
            if (beat_mode == 2 && in_wr && !DRAMCommandValid) begin
                stall_wr++;
                if (stall_wr >= 2) begin bt = 1'b1; stall_wr = 0; end
            end
            if (bt) beats_given++;
            BufDrain       = drn;
            WrBeatAccepted = bt;
            acc = DRAMCommandValid && DRAMCommandReady;
            if (acc) begin
                got_addr.push_back(DRAMAddress);
                got_cmd.push_back(DRAMCommand);
                if (drain_mode == 1 && in_rd) pend = 1'b1;
            end
            // Model update for the coming rising edge.
            if (drn && !(acc && in_rd)) begin
                if (credit_m < 8) credit_m++;
            end else if ((acc && in_rd) && !drn) begin
                credit_m--;
            end
            if (bt && !(acc && in_wr)) wr_m++;
            else if ((acc && in_wr) && !bt) wr_m--;
            prev_stall = DRAMCommandValid && !DRAMCommandReady;
            pa = DRAMAddress;
            pc = DRAMCommand;
            if (done_cnt > 0 && !pend) fin = 1'b1;
            @(negedge Clock);
            cyc++;
        end
        BufDrain = 1'b0;
        WrBeatAccepted = 1'b0;
        DRAMCommandReady = 1'b1;
        chk("op_within_budget", fin, 1);
        chk("done_single_pulse", Done, 0);
        chk("opready_after_done", OpReady, 1);
    endtask

    task automatic cmp_path(input string name, input int n_rd, input int n_wr, input int ea [8]);
        chk({name, "_count"}, got_addr.size(), n_rd + n_wr);
        for (int i = 0; i < got_addr.size() && i < n_rd + n_wr; i++) begin
            chk({name, "_addr"}, got_addr[i], ea[i % 8]);
            chk({name, "_cmd"}, got_cmd[i], (i < n_rd) ? 3'b001 : 3'b000);
        end
        chk({name, "_done"}, done_cnt, 1);
    endtask

    initial begin
        tbl[0] = '{op: 2'b01, leaf: 3'd5, n_rd: 8, n_wr: 0, rdy: 0, addr: '{0, 8, 32, 40, 80, 88, 192, 200}};
        tbl[1] = '{op: 2'b10, leaf: 3'd7, n_rd: 0, n_wr: 8, rdy: 0, addr: '{0, 8, 32, 40, 96, 104, 224, 232}};
        tbl[2] = '{op: 2'b11, leaf: 3'd3, n_rd: 8, n_wr: 8, rdy: 0, addr: '{0, 8, 16, 24, 64, 72, 160, 168}};
        tbl[3] = '{op: 2'b00, leaf: 3'd2, n_rd: 0, n_wr: 0, rdy: 0, addr: '{0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[4] = '{op: 2'b01, leaf: 3'd6, n_rd: 8, n_wr: 0, rdy: 0, addr: '{0, 8, 32, 40, 96, 104, 208, 216}};
        tbl[5] = '{op: 2'b11, leaf: 3'd5, n_rd: 8, n_wr: 8, rdy: 1, addr: '{0, 8, 32, 40, 80, 88, 192, 200}};
        p_leaf0 = '{0, 8, 16, 24, 48, 56, 112, 120};
        p_leaf7 = '{0, 8, 32, 40, 96, 104, 224, 232};

        Reset = 1'b0; Op = 2'b00; Leaf = 3'd0; OpValid = 1'b0;
        DRAMCommandReady = 1'b1; WrBeatAccepted = 1'b0; BufDrain = 1'b0;
        credit_m = 8; wr_m = 0;

        // Reset state.
        @(negedge Clock);
        @(negedge Clock);
        chk("rst_opready", OpReady, 0);
        chk("rst_valid", DRAMCommandValid, 0);
        chk("rst_done", Done, 0);
        chk("rst_addr", DRAMAddress, 0);
        chk("rst_cmd", DRAMCommand, 3'b001);
        chk("rst_ovf", OverflowErr, 0);
        Reset = 1'b1;
        @(negedge Clock);
        chk("opready_first_edge", OpReady, 1);

        // Table of path operations.
        for (int t = 0; t < 6; t++) begin
            issue_op(tbl[t].op, tbl[t].leaf);
            run_loop(tbl[t].n_rd, tbl[t].n_wr, tbl[t].rdy, 1, 1, (tbl[t].rdy != 0) ? 300 : 100);
            cmp_path($sformatf("vec%0d", t), tbl[t].n_rd, tbl[t].n_wr, tbl[t].addr);
        end
        chk("no_ovf_after_table", OverflowErr, 0);

        // Drain with the buffer empty: sticky error, and the credit holds at 8.
        pulse_drain();
        chk("overflow_set", OverflowErr, 1);

        // Read without drains: exactly 8 reads use up all the credit.
        issue_op(2'b01, 3'd0);
        run_loop(8, 0, 0, 0, 0, 100);
        cmp_path("starve", 8, 0, p_leaf0);

        // Zero credit: reads wait for drains, then writes wait for beats.
        issue_op(2'b11, 3'd7);
        run_loop(8, 8, 0, 2, 2, 400);
        cmp_path("withheld", 8, 8, p_leaf7);
        chk("overflow_sticky", OverflowErr, 1);

        // Drains in IDLE give credit back but issue no commands.
        for (int i = 0; i < 4; i++) pulse_drain();
        chk("idle_no_cmd", DRAMCommandValid, 0);

        // Asynchronous reset after 3 commands of a read phase.
        issue_op(2'b01, 3'd5);
        for (int i = 0; i < 3; i++) begin
            chk("pre_rst_valid", DRAMCommandValid, 1);
            chk("pre_rst_addr", DRAMAddress, tbl[0].addr[i]);
            @(negedge Clock);
        end
        chk("pre_rst_still_valid", DRAMCommandValid, 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_rst_valid", DRAMCommandValid, 0);
        chk("async_rst_opready", OpReady, 0);
        chk("async_rst_addr", DRAMAddress, 0);
        chk("async_rst_cmd", DRAMCommand, 3'b001);
        chk("async_rst_ovf", OverflowErr, 0);
        credit_m = 8; wr_m = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("rst_no_done", Done, 0);
        end
        Reset = 1'b1;
        @(negedge Clock);
        chk("opready_after_release", OpReady, 1);
        chk("no_done_after_release", Done, 0);
        issue_op(2'b10, 3'd5);
        run_loop(0, 8, 0, 1, 1, 100);
        cmp_path("post_rst_write", 0, 8, tbl[0].addr);
        chk("post_rst_ovf", OverflowErr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
